// File: rtl/univ_shift_reg_param.sv
// Universal shift register with a direct mode and a counted burst mode.
// Optional feature macro: USR_ROTATE_EN enables rotate codes 100/101 (hold otherwise).
module univ_shift_reg_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [2:0]            sel_mux,
    input  logic                  sr,
    input  logic                  sl,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  shift_cnt,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_q;
    logic [2:0]            r_mode;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_q_nxt;
    logic [2:0]            w_mode_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [2:0]            w_op_mode;
    logic [DATA_WIDTH-1:0] w_op_q;

    // A burst runs the latched mode; otherwise the live select drives the datapath.
    assign w_op_mode = (r_state == ST_RUN) ? r_mode : sel_mux;

    // One operation of the selected mode applied to the current contents.
    always_comb begin
        w_op_q = r_q;
        case (w_op_mode)
            3'b001:  w_op_q = {sr, r_q[DATA_WIDTH-1:1]};
            3'b010:  w_op_q = {r_q[DATA_WIDTH-2:0], sl};
            3'b011:  w_op_q = in;
`ifdef USR_ROTATE_EN
            3'b100:  w_op_q = {r_q[0], r_q[DATA_WIDTH-1:1]};
            3'b101:  w_op_q = {r_q[DATA_WIDTH-2:0], r_q[DATA_WIDTH-1]};
`endif
            3'b110:  w_op_q = {r_q[DATA_WIDTH-1], r_q[DATA_WIDTH-1:1]};
            default: w_op_q = r_q;
        endcase
    end

    // Next-state, datapath and flag logic.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_mode_nxt = sel_mux;
                    w_cnt_nxt  = shift_cnt;
                    if (shift_cnt != CNT_WIDTH'(0)) begin
                        w_state_nxt = ST_RUN;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end else begin
                    w_q_nxt = w_op_q;
                end
            end
            ST_RUN: begin
                w_q_nxt   = w_op_q;
                w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
                if (r_cnt == CNT_WIDTH'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_mode  <= 3'b000;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_mode  <= w_mode_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign q_out = r_q;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_univ_shift_reg_param.sv
// Directed bench for univ_shift_reg_param (DATA_WIDTH=8, CNT_WIDTH=4).
// Rotate expectations follow USR_ROTATE_EN as seen by this file.
module tb_univ_shift_reg_param;

    logic       i_clk = 1'b0;
    logic       clr;
    logic [7:0] in;
    logic [2:0] sel_mux;
    logic       sr;
    logic       sl;
    logic       start;
    logic [3:0] shift_cnt;
    logic [7:0] q_out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    univ_shift_reg_param #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
        .i_clk(i_clk), .clr(clr), .in(in), .sel_mux(sel_mux), .sr(sr), .sl(sl),
        .start(start), .shift_cnt(shift_cnt), .q_out(q_out), .busy(busy), .done(done)
    );

    always #5 i_clk = ~i_clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        sel_mux = 3'b011; in = v; start = 1'b0;
        tick();
        sel_mux = 3'b000;
    endtask

    task automatic test_reset();
        clr = 1'b0; in = 8'h00; sel_mux = 3'b011; sr = 1'b0; sl = 1'b0; start = 1'b0; shift_cnt = 4'd0;
        #12;
        checks++; if (q_out !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp %h", q_out, 8'h00); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        sel_mux = 3'b000;
        #5 clr = 1'b1;
    endtask

    task automatic test_direct();
        load(8'hA5);
        checks++; if (q_out !== 8'hA5) begin errors++; $display("FAIL direct_load got %h exp %h", q_out, 8'hA5); end
        sel_mux = 3'b001; sr = 1'b1;
        tick();
        checks++; if (q_out !== 8'hD2) begin errors++; $display("FAIL direct_shr got %h exp %h", q_out, 8'hD2); end
        sel_mux = 3'b010; sl = 1'b0;
        tick();
        checks++; if (q_out !== 8'hA4) begin errors++; $display("FAIL direct_shl got %h exp %h", q_out, 8'hA4); end
        sel_mux = 3'b110;
        tick();
        checks++; if (q_out !== 8'hD2) begin errors++; $display("FAIL direct_asr got %h exp %h", q_out, 8'hD2); end
        sel_mux = 3'b111;
        tick();
        checks++; if (q_out !== 8'hD2) begin errors++; $display("FAIL direct_hold111 got %h exp %h", q_out, 8'hD2); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL direct_flags got %b%b exp 00", busy, done); end
        sel_mux = 3'b000;
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate();
        load(8'h81);
        sel_mux = 3'b100;
        tick();
        checks++; if (q_out !== 8'hC0) begin errors++; $display("FAIL rot_right got %h exp %h", q_out, 8'hC0); end
        load(8'h81);
        sel_mux = 3'b101; shift_cnt = 4'd3; start = 1'b1;
        tick();
        checks++; if (q_out !== 8'h81 || busy !== 1'b1) begin errors++; $display("FAIL rol_accept got %h/%b exp 81/1", q_out, busy); end
        start = 1'b0; sel_mux = 3'b011; in = 8'h00; shift_cnt = 4'd0;
        tick();
        checks++; if (q_out !== 8'h03 || busy !== 1'b1) begin errors++; $display("FAIL rol_1 got %h/%b exp 03/1", q_out, busy); end
        sel_mux = 3'b000;
        tick();
        checks++; if (q_out !== 8'h06 || busy !== 1'b1) begin errors++; $display("FAIL rol_2 got %h/%b exp 06/1", q_out, busy); end
        tick();
        checks++; if (q_out !== 8'h0C || busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL rol_3 got %h/%b/%b exp 0c/0/1", q_out, busy, done); end
        tick();
        checks++; if (done !== 1'b0 || q_out !== 8'h0C) begin errors++; $display("FAIL rol_done_pulse got %b/%h exp 0/0c", done, q_out); end
    endtask
`else
    task automatic test_rotate();
        load(8'h81);
        sel_mux = 3'b100;
        tick();
        checks++; if (q_out !== 8'h81) begin errors++; $display("FAIL norot_1 got %h exp %h", q_out, 8'h81); end
        tick();
        checks++; if (q_out !== 8'h81) begin errors++; $display("FAIL norot_2 got %h exp %h", q_out, 8'h81); end
        sel_mux = 3'b101; shift_cnt = 4'd2; start = 1'b1;
        tick();
        start = 1'b0; sel_mux = 3'b000;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL norot_busy got %b exp 1", busy); end
        tick();
        tick();
        checks++; if (q_out !== 8'h81 || done !== 1'b1) begin errors++; $display("FAIL norot_burst got %h/%b exp 81/1", q_out, done); end
    endtask
`endif

    task automatic test_asr_zero_cnt();
        load(8'h90);
        sel_mux = 3'b110; shift_cnt = 4'd2; start = 1'b1;
        tick();
        checks++; if (q_out !== 8'h90 || busy !== 1'b1) begin errors++; $display("FAIL asr_accept got %h/%b exp 90/1", q_out, busy); end
        start = 1'b0; sel_mux = 3'b000;
        tick();
        checks++; if (q_out !== 8'hC8) begin errors++; $display("FAIL asr_1 got %h exp %h", q_out, 8'hC8); end
        tick();
        checks++; if (q_out !== 8'hE4 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL asr_2 got %h/%b/%b exp e4/0/1", q_out, busy, done); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL asr_done_clear got %b exp 0", done); end
        sel_mux = 3'b110; shift_cnt = 4'd0; start = 1'b1;
        tick();
        checks++; if (q_out !== 8'hE4 || busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL zero_cnt got %h/%b/%b exp e4/0/1", q_out, busy, done); end
        start = 1'b0; sel_mux = 3'b000;
        tick();
        checks++; if (q_out !== 8'hE4 || done !== 1'b0) begin errors++; $display("FAIL zero_cnt_after got %h/%b exp e4/0", q_out, done); end
    endtask

    task automatic test_clr_abort();
        load(8'h00);
        sel_mux = 3'b010; sl = 1'b1; shift_cnt = 4'd10; start = 1'b1;
        tick();
        start = 1'b0; sel_mux = 3'b000;
        for (int k = 0; k < 4; k++) tick();
        checks++; if (q_out !== 8'h0F || busy !== 1'b1) begin errors++; $display("FAIL abort_pre got %h/%b exp 0f/1", q_out, busy); end
        #2 clr = 1'b0;
        #1;
        checks++; if (q_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_async got %h/%b/%b exp 00/0/0", q_out, busy, done); end
        #3 clr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (q_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_quiet%0d got %h/%b/%b exp 00/0/0", k, q_out, busy, done); end
        end
        sl = 1'b0;
    endtask

    task automatic test_back_to_back();
        load(8'hFF);
        sel_mux = 3'b001; sr = 1'b0; shift_cnt = 4'd1; start = 1'b1;
        tick();
        checks++; if (q_out !== 8'hFF || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept1 got %h/%b exp ff/1", q_out, busy); end
        start = 1'b0; sel_mux = 3'b000;
        tick();
        checks++; if (q_out !== 8'h7F || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_first got %h/%b/%b exp 7f/0/1", q_out, busy, done); end
        sel_mux = 3'b010; sl = 1'b0; shift_cnt = 4'd1; start = 1'b1;
        tick();
        checks++; if (q_out !== 8'h7F || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept2 got %h/%b/%b exp 7f/1/0", q_out, busy, done); end
        start = 1'b0; sel_mux = 3'b000;
        tick();
        checks++; if (q_out !== 8'hFE || done !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b exp fe/1", q_out, done); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear got %b exp 0", done); end
    endtask

    task automatic test_long_burst();
        load(8'h00);
        sel_mux = 3'b001; sr = 1'b1; shift_cnt = 4'd15; start = 1'b1;
        tick();
        start = 1'b0; sel_mux = 3'b000;
        for (int k = 1; k < 15; k++) begin
            tick();
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL long_busy%0d got %b exp 1", k, busy); end
            if (k == 4) begin
                checks++; if (q_out !== 8'hF0) begin errors++; $display("FAIL long_mid got %h exp %h", q_out, 8'hF0); end
            end
        end
        tick();
        checks++; if (q_out !== 8'hFF || busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL long_end got %h/%b/%b exp ff/0/1", q_out, busy, done); end
        sr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_direct();
        test_rotate();
        test_asr_zero_cnt();
        test_clr_abort();
        test_back_to_back();
        test_long_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
